// File: rtl/fxp_expand_stream_if.sv
// fxp_expand_stream_if: valid/ready sample stream, gain control and overflow flag for fxp_expand_stream
interface fxp_expand_stream_if #(
  parameter int NB_XI   = 8,
  parameter int NB_XO   = 20,
  parameter int SHIFT_W = 3
);
  logic [NB_XI-1:0]   i_data;
  logic               i_valid;
  logic               o_ready;
  logic [SHIFT_W-1:0] i_shift;
  logic [NB_XO-1:0]   o_data;
  logic               o_valid;
  logic               i_ready;
  logic               o_ovf;
  logic               i_ovf_clr;
  modport slave (
    input  i_data, i_valid, i_shift, i_ready, i_ovf_clr,
    output o_ready, o_data, o_valid, o_ovf
  );
  modport master (
    output i_data, i_valid, i_shift, i_ready, i_ovf_clr,
    input  o_ready, o_data, o_valid, o_ovf
  );
endinterface

// File: rtl/fxp_expand_stream.sv
// fxp_expand_stream: S(NB_XI,NBF_XI) to S(NB_XO,NBF_XO) widener with 2^shift gain and saturation; FXP_EXPAND_OVF_CNT_EN adds o_ovf_cnt
module fxp_expand_stream #(
  parameter int NB_XI   = 8,
  parameter int NBF_XI  = 6,
  parameter int NB_XO   = 20,
  parameter int NBF_XO  = 12,
  parameter int SHIFT_W = 3
) (
  input  logic i_clock,
  input  logic i_reset,
  fxp_expand_stream_if.slave bus
`ifdef FXP_EXPAND_OVF_CNT_EN
  ,
  output logic [15:0] o_ovf_cnt
`endif
);
  localparam int PW = NB_XO + 2**SHIFT_W - 1;
  localparam int FS = NBF_XO - NBF_XI;
  logic          en, v1, sat, ovf_set;
  logic [PW-1:0] p, p1;
  logic [PW-NB_XO:0] top;
  assign en = ~bus.o_valid | bus.i_ready;
  assign bus.o_ready = en;
  assign p = PW'($signed(bus.i_data)) << (FS + int'(bus.i_shift));
  assign top = p1[PW-1:NB_XO-1];
  assign sat = ~(&top | ~|top);
  assign ovf_set = en & v1 & sat;
  // stage 1: align and shift the accepted sample
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      v1 <= 1'b0;
      p1 <= '0;
    end else if (en) begin
      v1 <= bus.i_valid;
      p1 <= p;
    end
  // stage 2: saturate to the output width and track overflow
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      bus.o_data  <= '0;
      bus.o_valid <= 1'b0;
      bus.o_ovf   <= 1'b0;
    end else begin
      if (en) begin
        bus.o_valid <= v1;
        bus.o_data  <= !sat ? p1[NB_XO-1:0] : p1[PW-1] ? {1'b1, {(NB_XO-1){1'b0}}} : {1'b0, {(NB_XO-1){1'b1}}};
      end
      bus.o_ovf <= ovf_set | (bus.o_ovf & ~bus.i_ovf_clr);
    end
`ifdef FXP_EXPAND_OVF_CNT_EN
  // saturating count of saturated samples; clear coinciding with a saturation leaves 1
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) o_ovf_cnt <= '0;
    else o_ovf_cnt <= bus.i_ovf_clr ? 16'(ovf_set) : (ovf_set && o_ovf_cnt != 16'hFFFF) ? o_ovf_cnt + 16'd1 : o_ovf_cnt;
`endif
endmodule
